// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver states, parity modes and width helpers.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;
   function automatic int cnt_w(input int os);
      return $clog2(os);
   endfunction
   function automatic int idx_w(input int db);
      return $clog2(db + 1);
   endfunction
endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: received-word holding register handshake and status flags.
interface uart_rx_frame_ctrl_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] rx_data;
   logic rx_valid;
   logic rx_ready;
   logic rx_parity_err;
   logic rx_frame_err;
   logic rx_break;
   logic rx_overrun;
   modport master (output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun,
                   input rx_ready);
   modport slave (input rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun,
                  output rx_ready);
endinterface

// File: rtl/uart_rx_frame_ctrl_sampler.sv
// uart_rx_sampler: 2-flop synchroniser, start-edge detect and per-sample value.
// UART_RX_MAJORITY_VOTE_EN selects a 3-sample majority instead of a single sample.
module uart_rx_sampler (
   input  logic clk,
   input  logic resetn,
   input  logic ip_rx_data,
   output logic s_rx,
   output logic fall_edge,
   output logic sample_val
);
   logic s1, s2, s3;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) {s1, s2, s3} <= 3'b111;
      else {s1, s2, s3} <= {ip_rx_data, s1, s2};
   assign s_rx = s2;
   assign fall_edge = s3 & ~s2;
`ifdef UART_RX_MAJORITY_VOTE_EN
   logic s4;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) s4 <= 1'b1;
      else s4 <= s3;
   assign sample_val = (s2 & s3) | (s2 & s4) | (s3 & s4);
`else
   assign sample_val = s2;
`endif
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parametrised UART receiver with error flags and one-word holding register.
// Build option UART_RX_MAJORITY_VOTE_EN enables majority-vote sampling in the sampler.
module uart_rx_frame_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic clk,
   input  logic resetn,
   input  logic ip_rx_data,
   uart_rx_frame_ctrl_if.master rx
);
   localparam int CW = cnt_w(OVERSAMPLE);
   localparam int IW = idx_w(DATA_BITS);

   if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE % 2) != 0 ||
       PARITY_MODE < 0 || PARITY_MODE > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
      $fatal(1, "uart_rx_frame_ctrl: illegal parameter value");
   end

   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [IW-1:0] idx, idx_n;
   logic [DATA_BITS-1:0] sh, sh_n, data_q;
   logic perr, perr_n, ferr, ferr_n, brk, brk_n, pbit, pbit_n, done;
   logic valid_q, pe_q, fe_q, brk_q, ovr_q;
   logic s_rx, fall_edge, sample_val, half, full, accept, load;

   uart_rx_sampler u_sampler (
      .clk(clk), .resetn(resetn), .ip_rx_data(ip_rx_data),
      .s_rx(s_rx), .fall_edge(fall_edge), .sample_val(sample_val)
   );

   assign half = cnt == CW'(OVERSAMPLE / 2 - 1);
   assign full = cnt == CW'(OVERSAMPLE - 1);

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         {perr, ferr, brk, pbit} <= 4'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         sh    <= sh_n;
         {perr, ferr, brk, pbit} <= {perr_n, ferr_n, brk_n, pbit_n};
      end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      sh_n    = sh;
      perr_n  = perr;
      ferr_n  = ferr;
      brk_n   = brk;
      pbit_n  = pbit;
      done    = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (fall_edge && !s_rx) state_n = START;
         end
         START: if (half) begin
            cnt_n = '0;
            idx_n = '0;
            {perr_n, ferr_n, brk_n, pbit_n} = 4'b0;
            state_n = sample_val ? IDLE : DATA;
         end
         DATA: if (full) begin
            cnt_n = '0;
            sh_n  = {sample_val, sh[DATA_BITS-1:1]};
            idx_n = idx + 1'b1;
            if (idx == IW'(DATA_BITS - 1)) begin
               idx_n   = '0;
               state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end
         end
         PARITY: if (full) begin
            cnt_n   = '0;
            pbit_n  = sample_val;
            perr_n  = (^{sh, sample_val}) ^ (PARITY_MODE == PARITY_ODD);
            state_n = STOP;
         end
         STOP: if (full) begin
            cnt_n  = '0;
            idx_n  = idx + 1'b1;
            ferr_n = ferr | ~sample_val;
            // break is judged on the first stop bit only
            if (idx == '0) brk_n = ~|sh & ~pbit & ~sample_val;
            if (idx == IW'(STOP_BITS - 1)) begin
               state_n = IDLE;
               done    = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign accept = valid_q & rx.rx_ready;
   assign load   = done & (~valid_q | rx.rx_ready);

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         data_q  <= '0;
         {valid_q, pe_q, fe_q, brk_q, ovr_q} <= 5'b0;
      end else begin
         if (load) begin
            data_q  <= sh;
            pe_q    <= perr;
            fe_q    <= ferr_n;
            brk_q   <= brk_n;
            valid_q <= 1'b1;
         end else if (done) ovr_q <= 1'b1;
         else if (accept) valid_q <= 1'b0;
         if (accept) ovr_q <= 1'b0;
      end

   assign rx.rx_data       = data_q;
   assign rx.rx_valid      = valid_q;
   assign rx.rx_parity_err = pe_q;
   assign rx.rx_frame_err  = fe_q;
   assign rx.rx_break      = brk_q;
   assign rx.rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames on 8N1, 7E1 and 8N2 receivers with hand-computed results.
module tb_uart_rx_frame_ctrl;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic rxl [3];
   int checks = 0;
   int errors = 0;
   int pulses = 0;
   logic [7:0] cap_data = '0;
   logic [2:0] cap_flags = '0;

   always #5 clk = ~clk;

   uart_rx_frame_ctrl_if #(.DATA_BITS(8)) if0 ();
   uart_rx_frame_ctrl_if #(.DATA_BITS(7)) if1 ();
   uart_rx_frame_ctrl_if #(.DATA_BITS(8)) if2 ();

   uart_rx_frame_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .resetn(resetn), .ip_rx_data(rxl[0]), .rx(if0));
   uart_rx_frame_ctrl #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .resetn(resetn), .ip_rx_data(rxl[1]), .rx(if1));
   uart_rx_frame_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) dut2 (
      .clk(clk), .resetn(resetn), .ip_rx_data(rxl[2]), .rx(if2));

   always @(negedge clk)
      if (if0.rx_valid && if0.rx_ready) begin
         pulses    <= pulses + 1;
         cap_data  <= if0.rx_data;
         cap_flags <= {if0.rx_parity_err, if0.rx_frame_err, if0.rx_break};
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int d, input logic [15:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         rxl[d] = b[i];
         repeat (16) @(negedge clk);
      end
      rxl[d] = 1'b1;
   endtask

   task automatic gap();
      repeat (32) @(negedge clk);
   endtask

   task automatic consume(input int d);
      if (d == 0) if0.rx_ready = 1'b1;
      else if (d == 1) if1.rx_ready = 1'b1;
      else if2.rx_ready = 1'b1;
      @(negedge clk);
      if0.rx_ready = 1'b0;
      if1.rx_ready = 1'b0;
      if2.rx_ready = 1'b0;
   endtask

   function automatic logic [15:0] f8n1(input logic [7:0] d);
      return {7'h7F, d, 1'b0};
   endfunction
   function automatic logic [15:0] f7e1(input logic [6:0] d, input logic p);
      return {6'h3F, p, d, 1'b0};
   endfunction
   function automatic logic [15:0] f8n2(input logic [7:0] d, input logic s1, input logic s2);
      return {5'h1F, s2, s1, d, 1'b0};
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) rxl[i] = 1'b1;
      if0.rx_ready = 1'b0;
      if1.rx_ready = 1'b0;
      if2.rx_ready = 1'b0;
      repeat (4) @(negedge clk);
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_valid0", 32'(if0.rx_valid), 0);
      check("rst_data0", 32'(if0.rx_data), 0);
      check("rst_ovr0", 32'(if0.rx_overrun), 0);
      check("rst_perr1", 32'(if1.rx_parity_err), 0);
      check("rst_ferr2", 32'(if2.rx_frame_err), 0);
      check("rst_brk2", 32'(if2.rx_break), 0);

      if0.rx_ready = 1'b1;
      drive(0, f8n1(8'hA5), 10);
      gap();
      check("base_pulses", 32'(pulses), 1);
      check("base_data", 32'(cap_data), 32'hA5);
      check("base_flags", 32'(cap_flags), 0);
      check("base_valid_low", 32'(if0.rx_valid), 0);

      rxl[0] = 1'b0;
      repeat (5) @(negedge clk);
      rxl[0] = 1'b1;
      gap();
      check("glitch_pulses", 32'(pulses), 1);
      drive(0, f8n1(8'h3C), 10);
      gap();
      check("glitch_next_pulses", 32'(pulses), 2);
      check("glitch_next_data", 32'(cap_data), 32'h3C);
      if0.rx_ready = 1'b0;

      drive(1, f7e1(7'h55, 1'b1), 10);
      gap();
      check("par_bad_valid", 32'(if1.rx_valid), 1);
      check("par_bad_data", 32'(if1.rx_data), 32'h55);
      check("par_bad_err", 32'(if1.rx_parity_err), 1);
      consume(1);
      check("par_consume", 32'(if1.rx_valid), 0);
      drive(1, f7e1(7'h55, 1'b0), 10);
      gap();
      check("par_ok_data", 32'(if1.rx_data), 32'h55);
      check("par_ok_err", 32'(if1.rx_parity_err), 0);
      consume(1);

      drive(2, f8n2(8'h81, 1'b1, 1'b0), 11);
      gap();
      check("frm_data", 32'(if2.rx_data), 32'h81);
      check("frm_err", 32'(if2.rx_frame_err), 1);
      check("frm_brk", 32'(if2.rx_break), 0);
      consume(2);
      rxl[2] = 1'b0;
      repeat (12 * 16) @(negedge clk);
      rxl[2] = 1'b1;
      gap();
      check("brk_valid", 32'(if2.rx_valid), 1);
      check("brk_data", 32'(if2.rx_data), 0);
      check("brk_ferr", 32'(if2.rx_frame_err), 1);
      check("brk_brk", 32'(if2.rx_break), 1);
      consume(2);

      drive(0, f8n1(8'h11), 10);
      gap();
      check("ovr_first_ovr", 32'(if0.rx_overrun), 0);
      drive(0, f8n1(8'h22), 10);
      gap();
      check("ovr_data", 32'(if0.rx_data), 32'h11);
      check("ovr_valid", 32'(if0.rx_valid), 1);
      check("ovr_flag", 32'(if0.rx_overrun), 1);
      consume(0);
      check("ovr_consume_valid", 32'(if0.rx_valid), 0);
      check("ovr_consume_flag", 32'(if0.rx_overrun), 0);
      check("ovr_hold_data", 32'(if0.rx_data), 32'h11);

      drive(0, f8n1(8'hF0), 5);
      rxl[0] = 1'b1;
      repeat (8) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("mid_rst_data", 32'(if0.rx_data), 0);
      check("mid_rst_valid", 32'(if0.rx_valid), 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      gap();
      check("mid_rst_no_frame", 32'(if0.rx_valid), 0);
      drive(0, f8n1(8'h0F), 10);
      gap();
      check("post_rst_valid", 32'(if0.rx_valid), 1);
      check("post_rst_data", 32'(if0.rx_data), 32'h0F);
      check("post_rst_flags", 32'({if0.rx_parity_err, if0.rx_frame_err, if0.rx_break, if0.rx_overrun}), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Configurable data width, parity, stop-bit count and oversample ratio. Adds an input synchroniser, start-glitch rejection, and parity/framing/break error detection. Output is a one-word holding register with a valid/ready handshake and overrun detection. Sits between the pad-side RX line and the RX FIFO/host interface; one clk cycle equals one oversample tick.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
OVERSAMPLE, 16, clk cycles per bit period; even; legal 4..64.
PARITY_MODE, 0, parity type: 0 none, 1 even, 2 odd.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
clk  in  1  system clock / oversample tick
resetn  in  1  asynchronous active-low reset
ip_rx_data  in  1  asynchronous serial line; idles high
rx_data  out  DATA_BITS  received word; valid while rx_valid=1
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts the word when rx_valid&&rx_ready
rx_parity_err  out  1  parity mismatch for the held word; qualified by rx_valid
rx_frame_err  out  1  a stop bit sampled low for the held word; qualified by rx_valid
rx_break  out  1  all data bits 0, parity (if any) 0 and first stop 0; qualified by rx_valid
rx_overrun  out  1  sticky: at least one frame was dropped

Behaviour:
- Reset (async, resetn=0): state IDLE; counters 0; synchroniser flops 1; rx_data 0; rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun all 0. Deassertion mid-frame drops the partial frame; the receiver restarts hunting for a start bit.
- Synchroniser: ip_rx_data passes through 2 flops; all logic uses the synchronised value s_rx. Start detect is s_rx 1->0, seen in IDLE only.
- Counters: bit-time counter is $clog2(OVERSAMPLE) bits wide; bit index is $clog2(DATA_BITS+1) bits wide.
- IDLE: on falling edge -> START, cnt=0.
- START: cnt increments each clk. At cnt==OVERSAMPLE/2-1, sample s_rx.
  - Sample 0 -> DATA, cnt=0, idx=0.
  - Sample 1 -> IDLE (glitch rejected, no flags).
- DATA: at cnt==OVERSAMPLE-1, shift the sample into bit idx and set cnt=0. After bit DATA_BITS-1 -> PARITY if PARITY_MODE!=0, else STOP.
- PARITY: one bit period; the sample is checked against XOR of the data bits.
  - Even mode: error if data^parity has odd weight.
  - Odd mode: error if it has even weight.
- STOP: one bit period per stop bit, sampled at cnt==OVERSAMPLE-1. Any stop sample 0 sets frame_err.
  - After the last stop sample -> IDLE directly.
  - No mid-stop wait: a new start edge is accepted from the next clk.
- Completion (the clk of the final stop sample), next-cycle effects:
  - If holding empty, or rx_valid&&rx_ready in that same cycle: load rx_data and the three error flags; rx_valid=1. Simultaneous consume and load gives no overrun.
  - Otherwise: discard the frame, set rx_overrun=1; the held word and its flags are unchanged.
- Handshake: rx_valid&&rx_ready with no completion -> rx_valid=0 next cycle. rx_data and flags hold their value (not zeroed). rx_overrun clears on any accepted handshake.
- Latency: rx_valid rises 1 clk after the last stop sample.
- Frame bit count: 1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS.
- Illegal parameter values: fatal elaboration error via generate-time check.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN.
- Defined: every sample (start, data, parity, stop) is the majority of s_rx at the sample clk and the two preceding clks (3-deep history register). Requires OVERSAMPLE>=4.
- Undefined: single sample of s_rx at the sample clk; the history register is not built.
- Timing is identical in both builds.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP); PARITY_NONE/EVEN/ODD constants; clog2-based width helper constants.
- Sub-module uart_rx_sampler: 2-flop synchroniser, falling-edge detect and optional majority vote. Outputs s_rx, fall_edge, sample_val.
- The FSM, shift register and holding register stay in uart_rx_frame_ctrl.

Test Plan:
- Base frame: DATA_BITS=8, PARITY_MODE=0, STOP_BITS=1, OVERSAMPLE=16, rx_ready=1; send 0xA5 -> one rx_valid pulse, rx_data=0xA5, all error flags 0.
- Glitch: 8-N-1, hold line low 5 clks then high -> no rx_valid; the next valid frame 0x3C is received correctly.
- Parity: PARITY_MODE=1, DATA_BITS=7; send 0x55 with parity bit 1 -> rx_data=0x55, rx_parity_err=1. With parity bit 0 -> rx_parity_err=0.
- Framing and break: STOP_BITS=2; send 0x81 with second stop 0 -> rx_frame_err=1, rx_break=0. Hold line low for 12 bit times -> rx_data=0x00, rx_frame_err=1, rx_break=1.
- Overrun: rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun=1. Raise rx_ready for one clk -> rx_valid=0, rx_overrun=0.
- Reset mid-frame: assert resetn=0 during data bit 4 of 0xF0 -> outputs zero immediately. After release, send 0x0F -> rx_data=0x0F, no flags set.
